// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO read-side packer.
package fifo_pkg;

    localparam int DEF_DSIZE = 8;
    localparam int DEF_RATIO = 4;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops words from a first-word-fall-through FIFO and packs RATIO of them into
// one wide output beat; a level flush request closes a partial packet.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE = DEF_DSIZE,
    parameter int RATIO = DEF_RATIO
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   m_last,
    output state_e                 dbg_state_o
);

    localparam int            CW       = $clog2(RATIO + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RATIO);

    typedef logic [RATIO-1:0][DSIZE-1:0] lanes_t;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    lanes_t                 acc_q, acc_d;
    logic                   m_valid_q, m_valid_d;
    logic [DSIZE*RATIO-1:0] m_data_q, m_data_d;
    logic [RATIO-1:0]       m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;

    logic                   out_free;
    logic                   pop;
    logic                   flush_done_c;
    logic [CW-1:0]          lane;
    logic [RATIO-1:0]       fill_mask;
    lanes_t                 acc_masked;

    // Output handshake: a beat transfers on a cycle with m_valid && m_ready;
    // while m_valid is high and m_ready low the beat is held unchanged, and a
    // new beat may load in the same cycle the current one transfers.
    always_comb begin : mask_logic
        out_free   = !m_valid_q || m_ready;
        fill_mask  = '0;
        acc_masked = '0;
        for (int i = 0; i < RATIO; i++) begin
            fill_mask[i] = (i < int'(cnt_q));
            if (fill_mask[i]) begin
                acc_masked[i] = acc_q[i];
            end
        end
    end

    always_comb begin : next_state
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        m_valid_d    = m_valid_q && !m_ready;
        m_data_d     = m_data_q;
        m_keep_d     = m_keep_q;
        m_last_d     = m_last_q;
        pop          = 1'b0;
        flush_done_c = 1'b0;
        lane         = cnt_q;

        case (state_q)
            ST_FILL: begin
                pop = rrst_n && !rempty && ((cnt_q < CNT_FULL) || out_free);
                if ((cnt_q == CNT_FULL) && out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = acc_q;
                    m_keep_d  = '1;
                    m_last_d  = 1'b0;
                    cnt_d     = '0;
                    lane      = '0;
                end
                // A pop while full only happens alongside the load above, so it lands in lane 0.
                if (pop) begin
                    for (int i = 0; i < RATIO; i++) begin
                        if (i == int'(lane)) begin
                            acc_d[i] = rdata;
                        end
                    end
                    cnt_d = lane + CW'(1);
                end
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                if (out_free) begin
                    flush_done_c = 1'b1;
                    state_d      = ST_FILL;
                    cnt_d        = '0;
                    if (cnt_q != '0) begin
                        m_valid_d = 1'b1;
                        m_data_d  = acc_masked;
                        m_keep_d  = fill_mask;
                        m_last_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            acc_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_last_q  <= m_last_d;
        end
    end

    assign rinc        = pop;
    assign flush_done  = flush_done_c;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_keep      = m_keep_q;
    assign m_last      = m_last_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FWFT source model, output monitor, and one task per scenario.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int DSIZE = 8;
  localparam int RATIO = 4;
  localparam int BW    = DSIZE * RATIO;
  localparam logic [RATIO-1:0] KEEP_ALL = '1;

  logic             rclk    = 1'b0;
  logic             rrst_n  = 1'b0;
  logic             rempty  = 1'b1;
  logic [DSIZE-1:0] rdata   = '0;
  logic             rinc;
  logic             flush   = 1'b0;
  logic             flush_done;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [BW-1:0]    m_data;
  logic [RATIO-1:0] m_keep;
  logic             m_last;
  state_e           dbg_state;

  int errors = 0;
  int checks = 0;

  // source FIFO contents and the words handed to it in the current scenario
  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE-1:0] sent_q[$];
  bit               rand_gate = 1'b0;

  // monitor records
  int               cyc = 0;
  logic [BW-1:0]    obs_data_q[$];
  logic [RATIO-1:0] obs_keep_q[$];
  logic             obs_last_q[$];
  int               xfer_cyc_q[$];
  logic [DSIZE-1:0] pop_q[$];
  int               pop_cyc_q[$];
  int               guard_viol = 0;
  int               stab_viol  = 0;
  int               fdone_cnt  = 0;
  logic [BW-1:0]    exp_q[$];

  fifo_rd_packer #(.DSIZE(DSIZE), .RATIO(RATIO)) dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .rempty      (rempty),
    .rdata       (rdata),
    .rinc        (rinc),
    .flush       (flush),
    .flush_done  (flush_done),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_keep      (m_keep),
    .m_last      (m_last),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 rclk = ~rclk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------- FWFT source model ----------------
  initial begin : source
    logic took;
    forever begin
      @(negedge rclk);
      took = rinc && !rempty;
      @(posedge rclk);
      #1;
      if (took && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!rand_gate || $urandom_range(0, 1) == 1)) begin
        rempty = 1'b0;
        rdata  = src_q[0];
      end else begin
        rempty = 1'b1;
        rdata  = DSIZE'($urandom);
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin : monitor
    logic             prev_stall;
    logic [BW-1:0]    prev_data;
    logic [RATIO-1:0] prev_keep;
    logic             prev_last;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_keep  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge rclk);
      cyc++;
      if (rinc && rempty) guard_viol++;
      if (rinc && !rempty) begin
        pop_q.push_back(rdata);
        pop_cyc_q.push_back(cyc);
      end
      if (flush_done) fdone_cnt++;
      if (prev_stall && rrst_n) begin
        if (!m_valid || m_data !== prev_data || m_keep !== prev_keep || m_last !== prev_last)
          stab_viol++;
      end
      if (rrst_n && m_valid && m_ready) begin
        obs_data_q.push_back(m_data);
        obs_keep_q.push_back(m_keep);
        obs_last_q.push_back(m_last);
        xfer_cyc_q.push_back(cyc);
      end
      prev_stall = rrst_n && m_valid && !m_ready;
      prev_data  = m_data;
      prev_keep  = m_keep;
      prev_last  = m_last;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic send(input logic [DSIZE-1:0] w);
    sent_q.push_back(w);
    src_q.push_back(w);
  endtask

  task automatic clear_obs();
    obs_data_q.delete();
    obs_keep_q.delete();
    obs_last_q.delete();
    xfer_cyc_q.delete();
    pop_q.delete();
    pop_cyc_q.delete();
    exp_q.delete();
    sent_q.delete();
    fdone_cnt = 0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (obs_data_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  // reference packing: lane i of a beat holds the i-th oldest word, unused lanes zero
  function automatic logic [BW-1:0] pack_words(input int start, input int n);
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i*DSIZE +: DSIZE] = sent_q[start + i];
    return b;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    tick(2);
    src_q.push_back(8'h5A);
    tick(2);
    @(negedge rclk);
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0 (rempty=%b)", rinc, rempty); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data); end
    checks++; if (m_keep !== '0) begin errors++; $display("FAIL reset_m_keep: got %b want 0", m_keep); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b want 0", m_last); end
    checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    checks++; if (dbg_state !== ST_FILL) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_FILL); end
    src_q.delete();
    tick(2);
    rrst_n = 1'b1;
    tick(3);
    checks++; if (pop_q.size() !== 0) begin errors++; $display("FAIL reset_no_pop: got %0d pops want 0", pop_q.size()); end
  endtask

  task automatic test_streaming();
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    e = pack_words(0, 4);
    wait_beats(1, 20);
    tick(3);
    checks++; if (obs_data_q.size() !== 1) begin errors++; $display("FAIL stream_count: got %0d beats want 1", obs_data_q.size()); end
    if (obs_data_q.size() > 0) begin
      checks++; if (obs_data_q[0] !== e) begin errors++; $display("FAIL stream_data: got %h want %h", obs_data_q[0], e); end
      checks++; if (obs_keep_q[0] !== KEEP_ALL) begin errors++; $display("FAIL stream_keep: got %b want %b", obs_keep_q[0], KEEP_ALL); end
      checks++; if (obs_last_q[0] !== 1'b0) begin errors++; $display("FAIL stream_last: got %b want 0", obs_last_q[0]); end
      if (pop_cyc_q.size() >= 4) begin
        checks++;
        if (xfer_cyc_q[0] - pop_cyc_q[3] !== 2) begin
          errors++; $display("FAIL stream_latency: got %0d cycles want 2", xfer_cyc_q[0] - pop_cyc_q[3]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b1;
    for (int i = 0; i < 3 * RATIO; i++) send(DSIZE'($urandom));
    for (int b = 0; b < 3; b++) exp_q.push_back(pack_words(b * RATIO, RATIO));
    wait_beats(3, 60);
    tick(2);
    checks++; if (obs_data_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d beats want 3", obs_data_q.size()); end
    for (int b = 0; b < 3 && b < obs_data_q.size(); b++) begin
      e = exp_q.pop_front();
      checks++; if (obs_data_q[b] !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", b, obs_data_q[b], e); end
      checks++; if (obs_keep_q[b] !== KEEP_ALL || obs_last_q[b] !== 1'b0) begin
        errors++; $display("FAIL b2b_keep_last[%0d]: got %b/%b want %b/0", b, obs_keep_q[b], obs_last_q[b], KEEP_ALL);
      end
      if (b > 0) begin
        checks++;
        if (xfer_cyc_q[b] - xfer_cyc_q[b-1] !== RATIO) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", b, xfer_cyc_q[b] - xfer_cyc_q[b-1], RATIO);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < 3 * RATIO; i++) send(DSIZE'($urandom));
    for (int b = 0; b < 3; b++) exp_q.push_back(pack_words(b * RATIO, RATIO));
    tick(30);
    @(negedge rclk);
    checks++; if (pop_q.size() !== 2 * RATIO) begin errors++; $display("FAIL bp_popped: got %0d want %0d", pop_q.size(), 2 * RATIO); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b want 0", rinc); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held: got %b want 1", m_valid); end
    checks++; if (src_q.size() !== RATIO) begin errors++; $display("FAIL bp_src_left: got %0d want %0d", src_q.size(), RATIO); end
    tick(1);
    m_ready = 1'b1;
    wait_beats(3, 60);
    tick(2);
    checks++; if (obs_data_q.size() !== 3) begin errors++; $display("FAIL bp_count: got %0d beats want 3", obs_data_q.size()); end
    for (int b = 0; b < 3 && b < obs_data_q.size(); b++) begin
      e = exp_q.pop_front();
      checks++; if (obs_data_q[b] !== e) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", b, obs_data_q[b], e); end
    end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_hold_stable: got %0d violations want 0", stab_viol); end
  endtask

  task automatic test_partial_flush();
    int k;
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b1;
    send(8'hA1); send(8'hA2); send(8'hA3);
    e = pack_words(0, 3);
    k = 0;
    while (pop_q.size() < 3 && k < 20) begin tick(1); k++; end
    tick(1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    wait_beats(1, 10);
    tick(2);
    checks++; if (obs_data_q.size() !== 1) begin errors++; $display("FAIL pflush_count: got %0d beats want 1", obs_data_q.size()); end
    if (obs_data_q.size() > 0) begin
      checks++; if (obs_data_q[0] !== e) begin errors++; $display("FAIL pflush_data: got %h want %h", obs_data_q[0], e); end
      checks++; if (obs_keep_q[0] !== RATIO'((1 << 3) - 1)) begin errors++; $display("FAIL pflush_keep: got %b want 0111", obs_keep_q[0]); end
      checks++; if (obs_last_q[0] !== 1'b1) begin errors++; $display("FAIL pflush_last: got %b want 1", obs_last_q[0]); end
    end
    checks++; if (fdone_cnt !== 1) begin errors++; $display("FAIL pflush_done: got %0d pulses want 1", fdone_cnt); end
  endtask

  task automatic test_empty_flush();
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b1;
    tick(1);
    flush = 1'b1;
    #1;
    send(DSIZE'($urandom));
    tick(1);
    flush = 1'b0;
    @(negedge rclk);
    checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL eflush_done: got %b want 1", flush_done); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL eflush_rinc: got %b want 0 (rempty=%b)", rinc, rempty); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL eflush_valid: got %b want 0", m_valid); end
    @(negedge rclk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL eflush_no_beat: got m_valid=%b want 0", m_valid); end
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    e = pack_words(0, 1);
    wait_beats(1, 10);
    tick(2);
    checks++; if (obs_data_q.size() !== 1) begin errors++; $display("FAIL eflush_tail_count: got %0d beats want 1", obs_data_q.size()); end
    if (obs_data_q.size() > 0) begin
      checks++; if (obs_data_q[0] !== e || obs_keep_q[0] !== RATIO'(1) || obs_last_q[0] !== 1'b1) begin
        errors++; $display("FAIL eflush_tail_beat: got %h/%b/%b want %h/0001/1", obs_data_q[0], obs_keep_q[0], obs_last_q[0], e);
      end
    end
    checks++; if (fdone_cnt !== 2) begin errors++; $display("FAIL eflush_done_count: got %0d want 2", fdone_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] e;
    clear_obs();
    m_ready = 1'b0;
    for (int i = 0; i < RATIO + 2; i++) send(DSIZE'($urandom));
    tick(20);
    @(negedge rclk);
    checks++; if (m_valid !== 1'b1 || pop_q.size() !== RATIO + 2) begin
      errors++; $display("FAIL rmid_setup: got valid=%b pops=%0d want 1/%0d", m_valid, pop_q.size(), RATIO + 2);
    end
    tick(1);
    rrst_n = 1'b0;
    @(negedge rclk);
    checks++; if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0) begin
      errors++; $display("FAIL rmid_in_reset: got valid=%b data=%h keep=%b want 0/0/0", m_valid, m_data, m_keep);
    end
    tick(1);
    rrst_n  = 1'b1;
    m_ready = 1'b1;
    tick(6);
    checks++; if (obs_data_q.size() !== 0) begin errors++; $display("FAIL rmid_stale: got %0d beats want 0", obs_data_q.size()); end
    clear_obs();
    for (int i = 0; i < RATIO; i++) send(DSIZE'($urandom));
    e = pack_words(0, RATIO);
    wait_beats(1, 20);
    tick(3);
    checks++; if (obs_data_q.size() !== 1) begin errors++; $display("FAIL rmid_count: got %0d beats want 1", obs_data_q.size()); end
    if (obs_data_q.size() > 0) begin
      checks++; if (obs_data_q[0] !== e || obs_keep_q[0] !== KEEP_ALL || obs_last_q[0] !== 1'b0) begin
        errors++; $display("FAIL rmid_beat: got %h/%b/%b want %h/%b/0", obs_data_q[0], obs_keep_q[0], obs_last_q[0], e, KEEP_ALL);
      end
    end
  endtask

  task automatic test_random_guard();
    int k;
    int bad_order;
    logic [BW-1:0] e;
    clear_obs();
    rand_gate = 1'b1;
    for (int i = 0; i < 8 * RATIO; i++) send(DSIZE'($urandom));
    for (int b = 0; b < 8; b++) exp_q.push_back(pack_words(b * RATIO, RATIO));
    k = 0;
    while (obs_data_q.size() < 8 && k < 600) begin
      tick(1);
      m_ready = ($urandom_range(0, 3) != 0);
      k++;
    end
    m_ready = 1'b1;
    tick(4);
    rand_gate = 1'b0;
    checks++; if (obs_data_q.size() !== 8) begin errors++; $display("FAIL rand_count: got %0d beats want 8", obs_data_q.size()); end
    for (int b = 0; b < 8 && b < obs_data_q.size(); b++) begin
      e = exp_q.pop_front();
      checks++; if (obs_data_q[b] !== e || obs_keep_q[b] !== KEEP_ALL || obs_last_q[b] !== 1'b0) begin
        errors++; $display("FAIL rand_beat[%0d]: got %h/%b/%b want %h/%b/0", b, obs_data_q[b], obs_keep_q[b], obs_last_q[b], e, KEEP_ALL);
      end
    end
    bad_order = 0;
    for (int i = 0; i < pop_q.size() && i < sent_q.size(); i++) if (pop_q[i] !== sent_q[i]) bad_order++;
    checks++; if (pop_q.size() !== sent_q.size() || bad_order !== 0) begin
      errors++; $display("FAIL rand_pop_order: got %0d pops, %0d out of order; want %0d, 0", pop_q.size(), bad_order, sent_q.size());
    end
    checks++; if (guard_viol !== 0) begin errors++; $display("FAIL empty_guard: got %0d rinc-while-empty cycles want 0", guard_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL rand_hold_stable: got %0d violations want 0", stab_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin : main
    test_reset();
    test_streaming();
    test_back_to_back();
    test_backpressure();
    test_partial_flush();
    test_empty_flush();
    test_reset_mid();
    test_random_guard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
